// File: rtl/picomem_pkg.sv
// picomem_pkg: shared PicoMem bus widths, arbiter state encoding and error data
package picomem_pkg;

    localparam int PICOMEM_AW = 32;
    localparam int PICOMEM_DW = 32;
    localparam int PICOMEM_SW = 4;

    localparam logic [PICOMEM_DW-1:0] PICOMEM_ERR_RDATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_e;

endpackage

// File: rtl/picomem_watchdog.sv
// picomem_watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th one
module picomem_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;

    // Clear beats count so every new transaction starts from zero
    always_comb begin
        cnt_d   = clr ? '0 : en ? cnt_q + 16'd1 : cnt_q;
        expired = en & (cnt_q == LAST);
    end

    // Cycle counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/picomem_arbiter_2to1.sv
// picomem_arbiter_2to1: round-robin 2:1 arbiter in front of one PicoMem SRAM slave
module picomem_arbiter_2to1
    import picomem_pkg::*;
#(
    parameter int unsigned            TIMEOUT   = 16,
    parameter logic [PICOMEM_DW-1:0]  ERR_RDATA = PICOMEM_ERR_RDATA
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_valid,
    input  logic [PICOMEM_AW-1:0] m0_addr,
    input  logic [PICOMEM_DW-1:0] m0_wdata,
    input  logic [PICOMEM_SW-1:0] m0_wstrb,
    output logic                  m0_ready,
    output logic [PICOMEM_DW-1:0] m0_rdata,
    input  logic                  m1_valid,
    input  logic [PICOMEM_AW-1:0] m1_addr,
    input  logic [PICOMEM_DW-1:0] m1_wdata,
    input  logic [PICOMEM_SW-1:0] m1_wstrb,
    output logic                  m1_ready,
    output logic [PICOMEM_DW-1:0] m1_rdata,
    output logic                  mem_s_valid,
    output logic [PICOMEM_AW-1:0] mem_s_addr,
    output logic [PICOMEM_DW-1:0] mem_s_wdata,
    output logic [PICOMEM_SW-1:0] mem_s_wstrb,
    input  logic                  mem_s_ready,
    input  logic [PICOMEM_DW-1:0] mem_s_rdata,
    output logic [1:0]            grant,
    output logic                  timeout_err
);

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic                  own0, own1, busy, expired, tmo, done;
    logic [PICOMEM_DW-1:0] rdata_sel;

    picomem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .en      (busy),
        .clr     (~busy | done),
        .expired (expired)
    );

    // Owner decode, request mux to the slave and response routing to the owner
    always_comb begin
        own0        = state_q == ST_GNT0;
        own1        = state_q == ST_GNT1;
        busy        = own0 | own1;
        tmo         = expired & ~mem_s_ready;
        done        = busy & (mem_s_ready | tmo);
        mem_s_valid = ~tmo & (own1 ? m1_valid : own0 & m0_valid);
        mem_s_addr  = own1 ? m1_addr  : own0 ? m0_addr  : '0;
        mem_s_wdata = own1 ? m1_wdata : own0 ? m0_wdata : '0;
        mem_s_wstrb = own1 ? m1_wstrb : own0 ? m0_wstrb : '0;
        rdata_sel   = mem_s_ready ? mem_s_rdata : ERR_RDATA;
        m0_ready    = own0 & done;
        m1_ready    = own1 & done;
        m0_rdata    = m0_ready ? rdata_sel : '0;
        m1_rdata    = m1_ready ? rdata_sel : '0;
        grant       = {own1, own0};
        timeout_err = err_q;
    end

    // Next state: pick the non-last master on a tie, always drop to IDLE after a completion
    always_comb begin
        state_d = busy ? (done ? ST_IDLE : state_q)
                       : (m0_valid & (~m1_valid | last_q)) ? ST_GNT0
                       : m1_valid ? ST_GNT1 : ST_IDLE;
        last_d  = done ? own1 : last_q;
        err_d   = err_q | tmo;
    end

    // State, round-robin history and sticky error registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule
